// File: rtl/csr_pkg.sv
// Shared CSR addresses, bit positions, cause codes and event encoding
// for the machine-mode CSR unit.
package csr_pkg;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned CAUSE_W = 4;
    localparam int unsigned HALF_W  = 32;

    localparam logic [ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [ADDR_W-1:0] CSR_MIE       = 12'h304;
    localparam logic [ADDR_W-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [ADDR_W-1:0] CSR_MEPC      = 12'h341;
    localparam logic [ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [ADDR_W-1:0] CSR_MIP       = 12'h344;
    localparam logic [ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIE_MTIE     = 7;
    localparam int unsigned MIE_MEIE     = 11;

    localparam logic [CAUSE_W-1:0] CAUSE_MTI = 4'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_MEI = 4'd11;

    typedef enum logic [1:0] {
        CSR_IDLE,
        CSR_TRAP,
        CSR_MRET
    } csr_evt_e;
endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes;
// any half write replaces the increment for that cycle.
module csr_counter64
    import csr_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                wr_lo,
    input  logic                wr_hi,
    input  logic [HALF_W-1:0]   wdata,
    output logic [2*HALF_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[HALF_W-1:0]        <= wdata;
            if (wr_hi) count[2*HALF_W-1:HALF_W] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end
endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer: CSR read/write, interrupt
// entry, MRET return and the mcycle/minstret counters.
module csr_unit
    import csr_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter logic [31:0] RESET_MTVEC = 32'h0,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic            csr_rd,
    input  logic            csr_wr,
    input  logic            is_mret,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] wdata,
    input  logic            timer_irq,
    input  logic            ext_irq,
    output logic [XLEN-1:0] rdata,
    output logic            epc_taken,
    output logic [XLEN-1:0] epc,
    output logic            irq_taken
);
    logic [ADDR_W-1:0]  addr;
    logic               mstatus_mie, mstatus_mpie;
    logic               mie_mtie, mie_meie;
    logic               mip_mtip, mip_meip;
    logic [XLEN-3:0]    mtvec_base;
    logic               mtvec_mode;
    logic [XLEN-3:0]    mepc_hi;
    logic [XLEN-1:0]    mcause;
    logic [63:0]        mcycle, minstret;

    logic               pend_t, pend_e, trap_cond, wr_en, vec_mode;
    logic [CAUSE_W-1:0] cause;
    csr_evt_e           evt;
    logic [XLEN-1:0]    mstatus_val, mie_val, mip_val, mtvec_val, mepc_val;
    logic [XLEN-1:0]    rd_val, trap_pc;
    logic               unused_bits;

    assign unused_bits = ^{inst[19:0], pc[1:0]};

    // Event decode: a pending enabled interrupt pre-empts MRET and CSR writes.
    always_comb begin
        addr      = inst[31:20];
        pend_t    = mip_mtip & mie_mtie;
        pend_e    = mip_meip & mie_meie;
        trap_cond = instr_valid & mstatus_mie & (pend_t | pend_e);
        cause     = pend_e ? CAUSE_MEI : CAUSE_MTI;
        evt       = CSR_IDLE;
        if (trap_cond) begin
            evt = CSR_TRAP;
        end else if (instr_valid && is_mret) begin
            evt = CSR_MRET;
        end
        wr_en = instr_valid & csr_wr & (evt != CSR_TRAP);
    end

    always_comb begin
        mstatus_val               = '0;
        mstatus_val[MSTATUS_MIE]  = mstatus_mie;
        mstatus_val[MSTATUS_MPIE] = mstatus_mpie;
        mie_val                   = '0;
        mie_val[MIE_MTIE]         = mie_mtie;
        mie_val[MIE_MEIE]         = mie_meie;
        mip_val                   = '0;
        mip_val[MIE_MTIE]         = mip_mtip;
        mip_val[MIE_MEIE]         = mip_meip;
        vec_mode                  = mtvec_mode & VECTORED_EN;
        mtvec_val                 = {mtvec_base, 1'b0, vec_mode};
        mepc_val                  = {mepc_hi, 2'b00};
        trap_pc                   = {mtvec_base, 2'b00}
                                  + (vec_mode ? XLEN'({cause, 2'b00}) : '0);
        rd_val                    = '0;
        case (addr)
            CSR_MSTATUS:   rd_val = mstatus_val;
            CSR_MIE:       rd_val = mie_val;
            CSR_MTVEC:     rd_val = mtvec_val;
            CSR_MEPC:      rd_val = mepc_val;
            CSR_MCAUSE:    rd_val = mcause;
            CSR_MIP:       rd_val = mip_val;
            CSR_MCYCLE:    rd_val = mcycle[31:0];
            CSR_MCYCLEH:   rd_val = mcycle[63:32];
            CSR_MINSTRET:  rd_val = minstret[31:0];
            CSR_MINSTRETH: rd_val = minstret[63:32];
            default:       rd_val = '0;
        endcase
    end

    always_comb begin
        rdata     = '0;
        epc_taken = 1'b0;
        epc       = '0;
        irq_taken = 1'b0;
        if (!rst) begin
            if (csr_rd) rdata = rd_val;
            case (evt)
                CSR_TRAP: begin
                    irq_taken = 1'b1;
                    epc_taken = 1'b1;
                    epc       = trap_pc;
                end
                CSR_MRET: begin
                    epc_taken = 1'b1;
                    epc       = mepc_val;
                end
                default: ;
            endcase
        end
    end

    // Trap/MRET updates follow the CSR write so they win on mstatus.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mip_mtip     <= 1'b0;
            mip_meip     <= 1'b0;
            mtvec_base   <= RESET_MTVEC[31:2];
            mtvec_mode   <= RESET_MTVEC[0];
            mepc_hi      <= '0;
            mcause       <= '0;
        end else begin
            mip_mtip <= timer_irq;
            mip_meip <= ext_irq;
            if (wr_en) begin
                case (addr)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= wdata[MSTATUS_MIE];
                        mstatus_mpie <= wdata[MSTATUS_MPIE];
                    end
                    CSR_MIE: begin
                        mie_mtie <= wdata[MIE_MTIE];
                        mie_meie <= wdata[MIE_MEIE];
                    end
                    CSR_MTVEC: begin
                        mtvec_base <= wdata[XLEN-1:2];
                        mtvec_mode <= wdata[0];
                    end
                    CSR_MEPC:   mepc_hi <= wdata[XLEN-1:2];
                    CSR_MCAUSE: mcause  <= wdata;
                    default: ;
                endcase
            end
            case (evt)
                CSR_TRAP: begin
                    mepc_hi      <= pc[XLEN-1:2];
                    mcause       <= {1'b1, (XLEN-1)'(cause)};
                    mstatus_mpie <= mstatus_mie;
                    mstatus_mie  <= 1'b0;
                end
                CSR_MRET: begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (wr_en && (addr == CSR_MCYCLE)),
        .wr_hi (wr_en && (addr == CSR_MCYCLEH)),
        .wdata (wdata),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instr_valid && (evt != CSR_TRAP)),
        .wr_lo (wr_en && (addr == CSR_MINSTRET)),
        .wr_hi (wr_en && (addr == CSR_MINSTRETH)),
        .wdata (wdata),
        .count (minstret)
    );
endmodule
